unified_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous memory (1-cycle read latency) between the core's instruction-fetch

---
 rtl/unified_mem_arbiter_if.sv | 43 ++++
 rtl/unified_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the core ports, the arbiter and the single-port memory.
// slave = arbiter side, master = core + memory side.
interface unified_mem_arbiter_if #(
  parameter int MEM_WORDS = 65536
) ();
  localparam int AW = $clog2(MEM_WORDS);

  logic          I_req;
  logic [31:0]   I_addr;
  logic          I_gnt;
  logic          I_rvalid;
  logic [31:0]   I_rdata;

  logic          D_req;
  logic          D_we;
  logic [3:0]    D_be;
  logic [31:0]   D_addr;
  logic [31:0]   D_wdata;
  logic          D_gnt;
  logic          D_rvalid;
  logic [31:0]   D_rdata;

  logic          Addr_err;

  logic          M_en;
  logic          M_we;
  logic [3:0]    M_be;
  logic [AW-1:0] M_addr;
  logic [31:0]   M_wdata;
  logic [31:0]   M_rdata;

  modport slave (
    input  I_req, I_addr, D_req, D_we, D_be, D_addr, D_wdata, M_rdata,
    output I_gnt, I_rvalid, I_rdata, D_gnt, D_rvalid, D_rdata, Addr_err,
           M_en, M_we, M_be, M_addr, M_wdata
  );

  modport master (
    output I_req, I_addr, D_req, D_we, D_be, D_addr, D_wdata, M_rdata,
    input  I_gnt, I_rvalid, I_rdata, D_gnt, D_rvalid, D_rdata, Addr_err,
           M_en, M_we, M_be, M_addr, M_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter in front of one single-port synchronous RAM.
// Data-first priority; fetch wins after MAX_D_STREAK back-to-back data grants.
// Responses return one cycle after grant, steered by a registered response FSM.
module unified_mem_arbiter #(
  parameter int MEM_WORDS    = 65536,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  unified_mem_arbiter_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [2:0] {
    RESP_NONE, RESP_I, RESP_D, RESP_ERR_I, RESP_ERR_D
  } resp_e;

  resp_e         state, state_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic          d_we_q, d_we_nxt;
  logic          i_win, d_win;
  logic          i_oor, d_oor;

  // Word index beyond the RAM: accepted but never reaches the memory.
  assign i_oor = bus.I_addr[31:2] >= 30'(MEM_WORDS);
  assign d_oor = bus.D_addr[31:2] >= 30'(MEM_WORDS);

  // Byte offset bits do not select anything in a word-wide RAM.
  logic unused_offs;
  assign unused_offs = ^{bus.I_addr[1:0], bus.D_addr[1:0]};

  // Grant: data first, fetch forced through once the data streak saturates.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (Reset_n) begin
      if (bus.D_req && !(bus.I_req && streak == STREAK_MAX)) d_win = 1'b1;
      else if (bus.I_req)                                    i_win = 1'b1;
    end
  end

  assign bus.I_gnt = i_win;
  assign bus.D_gnt = d_win;

  // Memory port carries the winner's request in the same cycle.
  always_comb begin
    bus.M_en    = 1'b0;
    bus.M_we    = 1'b0;
    bus.M_be    = 4'h0;
    bus.M_addr  = '0;
    bus.M_wdata = '0;
    if (i_win) begin
      bus.M_en   = !i_oor;
      bus.M_be   = 4'hF;
      bus.M_addr = bus.I_addr[2 +: AW];
    end else if (d_win) begin
      bus.M_en    = !d_oor;
      bus.M_we    = bus.D_we && !d_oor;
      bus.M_be    = bus.D_we ? bus.D_be : 4'hF;
      bus.M_addr  = bus.D_addr[2 +: AW];
      bus.M_wdata = bus.D_wdata;
    end
  end

  // Response state, data-write flag and streak counter registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state  <= RESP_NONE;
      streak <= '0;
      d_we_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      d_we_q <= d_we_nxt;
    end
  end

  // Next response from this cycle's grant; outputs decoded from the current response.
  always_comb begin
    state_nxt    = RESP_NONE;
    d_we_nxt     = d_we_q;
    streak_nxt   = streak;
    bus.I_rvalid = 1'b0;
    bus.I_rdata  = '0;
    bus.D_rvalid = 1'b0;
    bus.D_rdata  = '0;
    bus.Addr_err = 1'b0;

    if (i_win) begin
      state_nxt = i_oor ? RESP_ERR_I : RESP_I;
    end else if (d_win) begin
      state_nxt = d_oor ? RESP_ERR_D : RESP_D;
      d_we_nxt  = bus.D_we;
    end

    // Streak only counts data wins that actually kept a fetch waiting.
    if (!bus.I_req || i_win)                 streak_nxt = '0;
    else if (d_win && streak != STREAK_MAX)  streak_nxt = streak + SW'(1);

    // A response in flight when reset is asserted is dropped.
    if (Reset_n) begin
      case (state)
        RESP_I: begin
          bus.I_rvalid = 1'b1;
          bus.I_rdata  = bus.M_rdata;
        end
        RESP_D: begin
          bus.D_rvalid = 1'b1;
          bus.D_rdata  = d_we_q ? 32'h0 : bus.M_rdata;
        end
        RESP_ERR_I: begin
          bus.I_rvalid = 1'b1;
          bus.Addr_err = 1'b1;
        end
        RESP_ERR_D: begin
          bus.D_rvalid = 1'b1;
          bus.Addr_err = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vector table, contention/reset
// sequences, and random traffic against a transaction-level reference model.
module tb_unified_mem_arbiter;
  localparam int MEM_WORDS = 65536;
  localparam int MAX_D     = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  unified_mem_arbiter_if #(.MEM_WORDS(MEM_WORDS)) bus ();

  unified_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .MAX_D_STREAK(MAX_D)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  // Single-port synchronous RAM, one-cycle read latency.
  bit [31:0] mem [MEM_WORDS];
  always @(posedge Clk) begin
    if (bus.M_en) begin
      if (bus.M_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.M_be[b]) mem[bus.M_addr][8*b +: 8] = bus.M_wdata[8*b +: 8];
      end else begin
        bus.M_rdata <= mem[bus.M_addr];
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                        input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd);
    bus.I_req = ir; bus.I_addr = ia;
    bus.D_req = dr; bus.D_we = dw; bus.D_be = db; bus.D_addr = da; bus.D_wdata = dd;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit ir; logic [31:0] ia; bit dr; bit dw; logic [3:0] db; logic [31:0] da; logic [31:0] dd;
    bit e_ig; bit e_dg; bit e_en; bit e_we; logic [3:0] e_be; logic [31:0] e_ma;
    bit e_iv; bit e_dv; bit e_err; logic [31:0] e_rd;
  } vec_t;
  vec_t vt [8];

  // ---------------- reference model ----------------
  bit [31:0]   ref_mem [int];
  int          m_streak = 0;   // data wins in a row while fetch waited
  bit          pv = 0, p_i = 0, p_err = 0;
  logic [31:0] p_data = '0;
  bit          last_wi = 0, last_wd = 0;
  int          n_resp = 0;

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] hi, wd, lo;
    hi = (($urandom_range(0, 15) == 0) ? 32'($urandom_range(1, 16383)) : 32'h0) << 18;
    wd = 32'($urandom_range(0, 63)) << 2;
    lo = 32'($urandom_range(0, 3));
    return hi | wd | lo;
  endfunction

  // mode 0 random, 1 both held, 2 alternate I/D, 3 idle; unaccepted requests stay put.
  task automatic drive(input int mode, input int cyc);
    if (!(bus.I_req && !last_wi)) begin
      case (mode)
        0: bus.I_req = 1'($urandom_range(0, 1));
        1: bus.I_req = 1'b1;
        2: bus.I_req = (cyc % 2 == 0);
        default: bus.I_req = 1'b0;
      endcase
      bus.I_addr = rnd_addr();
    end
    if (!(bus.D_req && !last_wd)) begin
      case (mode)
        0: bus.D_req = 1'($urandom_range(0, 1));
        1: bus.D_req = 1'b1;
        2: bus.D_req = (cyc % 2 == 1);
        default: bus.D_req = 1'b0;
      endcase
      bus.D_we    = 1'($urandom_range(0, 1));
      bus.D_be    = 4'($urandom_range(0, 15));
      bus.D_addr  = rnd_addr();
      bus.D_wdata = $urandom;
    end
  endtask

  task automatic model_cycle();
    bit wi, wd, oor;
    logic [31:0] a, old;
    int w;
    @(negedge Clk);
    chk("I_rvalid", 32'(bus.I_rvalid), 32'(pv && p_i));
    chk("D_rvalid", 32'(bus.D_rvalid), 32'(pv && !p_i));
    chk("I_rdata",  bus.I_rdata, (pv && p_i)  ? p_data : 32'h0);
    chk("D_rdata",  bus.D_rdata, (pv && !p_i) ? p_data : 32'h0);
    chk("Addr_err", 32'(bus.Addr_err), 32'(pv && p_err));
    if (bus.I_rvalid || bus.D_rvalid) n_resp++;
    wi = bus.I_req && (!bus.D_req || m_streak == MAX_D);
    wd = bus.D_req && !wi;
    chk("I_gnt", 32'(bus.I_gnt), 32'(wi));
    chk("D_gnt", 32'(bus.D_gnt), 32'(wd));
    pv = wi || wd; p_i = wi; p_err = 0; p_data = '0;
    if (pv) begin
      a = wi ? bus.I_addr : bus.D_addr;
      w = int'(a >> 2);
      oor = (w >= MEM_WORDS);
      p_err = oor;
      chk("M_en", 32'(bus.M_en), 32'(!oor));
      if (!oor) begin
        chk("M_addr", 32'(bus.M_addr), 32'(w));
        if (wi || !bus.D_we) p_data = ref_rd(w);
        else begin
          old = ref_rd(w);
          for (int b = 0; b < 4; b++) if (bus.D_be[b]) old[8*b +: 8] = bus.D_wdata[8*b +: 8];
          ref_mem[w] = old;
        end
      end
    end else begin
      chk("M_en_idle", 32'(bus.M_en), 32'h0);
    end
    if (!bus.I_req || wi)           m_streak = 0;
    else if (wd && m_streak < MAX_D) m_streak++;
    last_wi = wi; last_wd = wd;
  endtask

  task automatic step(input int mode, input int cyc);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    drive(mode, cyc);
    model_cycle();
  endtask

  // One cycle with Reset_n low: everything must read zero; model restarts empty.
  task automatic reset_cycle(input string tag);
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    @(negedge Clk);
    chk({tag, "_I_gnt"},    32'(bus.I_gnt), 32'h0);
    chk({tag, "_D_gnt"},    32'(bus.D_gnt), 32'h0);
    chk({tag, "_I_rvalid"}, 32'(bus.I_rvalid), 32'h0);
    chk({tag, "_D_rvalid"}, 32'(bus.D_rvalid), 32'h0);
    chk({tag, "_rdata"},    bus.I_rdata | bus.D_rdata, 32'h0);
    chk({tag, "_Addr_err"}, 32'(bus.Addr_err), 32'h0);
    chk({tag, "_M"}, {26'h0, bus.M_en, bus.M_we, bus.M_be}, 32'h0);
    chk({tag, "_M_addr"},   32'(bus.M_addr), 32'h0);
    chk({tag, "_M_wdata"},  bus.M_wdata, 32'h0);
    pv = 0; m_streak = 0; last_wi = 0; last_wd = 0;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    mem[4]     = 32'h0000_0093;
    mem[12'h800] = 32'h1122_3344;

    //           ir ia            dr dw db    da            dd             ig dg en we be    ma        iv dv er rd
    vt[0] = '{1, 32'h10,        0, 0, 4'h0, 32'h0,        32'h0,         1, 0, 1, 0, 4'hF, 32'h4,    1, 0, 0, 32'h93};
    vt[1] = '{0, 32'h0,         1, 1, 4'h3, 32'h2000,     32'hAABBCCDD,  0, 1, 1, 1, 4'h3, 32'h800,  0, 1, 0, 32'h0};
    vt[2] = '{0, 32'h0,         1, 0, 4'h0, 32'h2000,     32'h0,         0, 1, 1, 0, 4'hF, 32'h800,  0, 1, 0, 32'h1122CCDD};
    vt[3] = '{0, 32'h0,         1, 0, 4'h0, 32'h0004_0000, 32'h0,        0, 1, 0, 0, 4'hF, 32'h0,    0, 1, 1, 32'h0};
    vt[4] = '{1, 32'h10,        1, 0, 4'h0, 32'h13,       32'h0,         0, 1, 1, 0, 4'hF, 32'h4,    0, 1, 0, 32'h93};
    vt[5] = '{1, 32'hFFFF_FFFC, 0, 0, 4'h0, 32'h0,        32'h0,         1, 0, 0, 0, 4'hF, 32'hFFFF, 1, 0, 1, 32'h0};
    vt[6] = '{0, 32'h0,         1, 1, 4'hF, 32'h0004_0008, 32'h12345678, 0, 1, 0, 0, 4'hF, 32'h2,    0, 1, 1, 32'h0};
    vt[7] = '{0, 32'h0,         0, 0, 4'h0, 32'h0,        32'h0,         0, 0, 0, 0, 4'h0, 32'h0,    0, 0, 0, 32'h0};

    // reset state
    reset_cycle("rst0");
    reset_cycle("rst1");

    // directed table: request cycle, then an idle cycle carrying the response
    for (int k = 0; k < 8; k++) begin
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      set_in(vt[k].ir, vt[k].ia, vt[k].dr, vt[k].dw, vt[k].db, vt[k].da, vt[k].dd);
      @(negedge Clk);
      chk($sformatf("v%0d_I_gnt", k),  32'(bus.I_gnt), 32'(vt[k].e_ig));
      chk($sformatf("v%0d_D_gnt", k),  32'(bus.D_gnt), 32'(vt[k].e_dg));
      chk($sformatf("v%0d_M_en", k),   32'(bus.M_en),  32'(vt[k].e_en));
      chk($sformatf("v%0d_M_we", k),   32'(bus.M_we),  32'(vt[k].e_we));
      chk($sformatf("v%0d_M_be", k),   32'(bus.M_be),  32'(vt[k].e_be));
      chk($sformatf("v%0d_M_addr", k), 32'(bus.M_addr), vt[k].e_ma);
      @(posedge Clk); #1;
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge Clk);
      chk($sformatf("v%0d_I_rvalid", k), 32'(bus.I_rvalid), 32'(vt[k].e_iv));
      chk($sformatf("v%0d_D_rvalid", k), 32'(bus.D_rvalid), 32'(vt[k].e_dv));
      chk($sformatf("v%0d_Addr_err", k), 32'(bus.Addr_err), 32'(vt[k].e_err));
      chk($sformatf("v%0d_I_rdata", k),  bus.I_rdata, vt[k].e_iv ? vt[k].e_rd : 32'h0);
      chk($sformatf("v%0d_D_rdata", k),  bus.D_rdata, vt[k].e_dv ? vt[k].e_rd : 32'h0);
    end

    // model starts from the RAM image the bench knows about
    ref_mem[4] = 32'h0000_0093;
    step(3, 0);

    // contention: D,D,D,D,I repeating
    for (int k = 0; k < 10; k++) begin
      step(1, k);
      chk($sformatf("order%0d", k), 32'(bus.I_gnt), 32'(k % 5 == 4));
    end

    // reset right after an I grant: its response must vanish
    reset_cycle("rstI");
    for (int k = 0; k < 4; k++) step(1, k);   // streak builds to MAX_D
    reset_cycle("rstS");
    step(1, 0);
    chk("post_reset_D_first", 32'(bus.D_gnt), 32'h1);

    // alternating single requests: every one answered exactly once
    for (int k = 0; k < 3; k++) step(3, k);
    n_resp = 0;
    for (int k = 0; k < 100; k++) begin
      step(2, k);
      chk("one_gnt", 32'(bus.I_gnt && bus.D_gnt), 32'h0);
    end
    step(3, 0);
    chk("alt_resp_count", 32'(n_resp), 32'd100);

    // random traffic
    for (int k = 0; k < 600; k++) step(0, k);
    for (int k = 0; k < 3; k++) step(3, k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
